// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer datapath: default widths
// and the MAC sequencer state encoding.
package fc_pkg;

  localparam int unsigned FC_NUM_MAC      = 4;
  localparam int unsigned FC_LEN_W        = 10;
  localparam int unsigned FC_GRP_W        = 8;
  localparam int unsigned FC_W_ADDR_W     = 16;
  localparam int unsigned FC_OUT_BITWIDTH = 26;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_LAST = 3'd2,
    ST_CAPT = 3'd3,
    ST_OUT  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/mac_seq_ctrl.sv
// Sequencer for NUM_MAC parallel MAC lanes: streams input/weight reads for each
// neuron group, captures lane accumulators and hands each result word downstream.
module mac_seq_ctrl
  import fc_pkg::*;
#(
  parameter int unsigned NUM_MAC      = FC_NUM_MAC,
  parameter int unsigned LEN_W        = FC_LEN_W,
  parameter int unsigned GRP_W        = FC_GRP_W,
  parameter int unsigned W_ADDR_W     = FC_W_ADDR_W,
  parameter int unsigned OUT_BITWIDTH = FC_OUT_BITWIDTH
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start,
  input  logic [LEN_W-1:0]                cfg_len,
  input  logic [GRP_W-1:0]                cfg_groups,
  input  logic                            mem_stall,
  output logic                            in_rd_en,
  output logic [LEN_W-1:0]                in_rd_addr,
  output logic                            w_rd_en,
  output logic [W_ADDR_W-1:0]             w_rd_addr,
  output logic                            mac_en,
  output logic                            mac_pause,
  input  logic [NUM_MAC*OUT_BITWIDTH-1:0] mac_dout,
  output logic                            res_valid,
  output logic [NUM_MAC*OUT_BITWIDTH-1:0] res_data,
  input  logic                            res_ready,
  output logic                            busy,
  output logic                            done
);

  seq_state_t                      r_state;
  seq_state_t                      w_state_nxt;
  logic [LEN_W-1:0]                r_idx;
  logic [LEN_W-1:0]                r_cfg_len;
  logic [GRP_W-1:0]                r_grp;
  logic [GRP_W-1:0]                r_cfg_groups;
  logic [W_ADDR_W-1:0]             r_w_ptr;
  logic                            r_rd_q;
  logic                            r_done;
  logic [NUM_MAC*OUT_BITWIDTH-1:0] r_res_data;

  logic w_idle_start;
  logic w_start_ok;
  logic w_rd_fire;
  logic w_last_rd;
  logic w_out_hs;
  logic w_last_grp;

  // A zero-sized job is acknowledged with done but never leaves IDLE.
  assign w_idle_start = (r_state == ST_IDLE) && start;
  assign w_start_ok   = w_idle_start && (cfg_len != '0) && (cfg_groups != '0);
  assign w_rd_fire    = (r_state == ST_RUN) && !mem_stall;
  assign w_last_rd    = w_rd_fire && (r_idx == r_cfg_len - LEN_W'(1));
  assign w_out_hs     = (r_state == ST_OUT) && res_ready;
  assign w_last_grp   = (r_grp == r_cfg_groups - GRP_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the next state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_start_ok) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last_rd)  w_state_nxt = ST_LAST;
      ST_LAST: w_state_nxt = ST_CAPT;
      ST_CAPT: w_state_nxt = ST_OUT;
      ST_OUT:  if (w_out_hs)   w_state_nxt = w_last_grp ? ST_IDLE : ST_RUN;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Read data arrives one cycle after its strobe, so lanes pause whenever the
  // previous cycle issued no read.
  always_comb begin
    in_rd_en  = 1'b0;
    w_rd_en   = 1'b0;
    mac_en    = 1'b0;
    mac_pause = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    unique case (r_state)
      ST_IDLE: busy = 1'b0;
      ST_RUN: begin
        in_rd_en  = w_rd_fire;
        w_rd_en   = w_rd_fire;
        mac_en    = 1'b1;
        mac_pause = !r_rd_q;
      end
      ST_LAST: begin
        mac_en    = 1'b1;
        mac_pause = !r_rd_q;
      end
      ST_OUT:  res_valid = 1'b1;
      default: ;
    endcase
  end

  assign in_rd_addr = r_idx;
  assign w_rd_addr  = r_w_ptr;
  assign res_data   = r_res_data;
  assign done       = r_done;

  // Weight pointer runs across groups; only the input index restarts per group.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_idx        <= '0;
      r_cfg_len    <= '0;
      r_grp        <= '0;
      r_cfg_groups <= '0;
      r_w_ptr      <= '0;
      r_rd_q       <= 1'b0;
      r_done       <= 1'b0;
      r_res_data   <= '0;
    end else begin
      r_done <= 1'b0;
      r_rd_q <= w_rd_fire;
      if (w_idle_start) begin
        if (w_start_ok) begin
          r_cfg_len    <= cfg_len;
          r_cfg_groups <= cfg_groups;
          r_idx        <= '0;
          r_grp        <= '0;
          r_w_ptr      <= '0;
        end else begin
          r_done <= 1'b1;
        end
      end
      if (w_rd_fire) begin
        r_idx   <= r_idx + LEN_W'(1);
        r_w_ptr <= r_w_ptr + W_ADDR_W'(1);
      end
      if (r_state == ST_CAPT) begin
        r_res_data <= mac_dout;
      end
      if (w_out_hs) begin
        r_idx  <= '0;
        r_grp  <= r_grp + GRP_W'(1);
        r_done <= w_last_grp;
      end
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: behavioural memories and MAC lanes around the DUT,
// results compared against dot products computed directly from memory contents.
module tb_mac_seq_ctrl;

  localparam int NUM_MAC  = fc_pkg::FC_NUM_MAC;
  localparam int LEN_W    = fc_pkg::FC_LEN_W;
  localparam int GRP_W    = fc_pkg::FC_GRP_W;
  localparam int W_ADDR_W = fc_pkg::FC_W_ADDR_W;
  localparam int OBW      = fc_pkg::FC_OUT_BITWIDTH;
  localparam int DW       = NUM_MAC * OBW;
  localparam int IN_D     = 1 << LEN_W;
  localparam int W_D      = 4096;
  localparam int LOGD     = 2048;

  logic                clk;
  logic                rstn;
  logic                start;
  logic [LEN_W-1:0]    cfg_len;
  logic [GRP_W-1:0]    cfg_groups;
  logic                mem_stall;
  logic                in_rd_en;
  logic [LEN_W-1:0]    in_rd_addr;
  logic                w_rd_en;
  logic [W_ADDR_W-1:0] w_rd_addr;
  logic                mac_en;
  logic                mac_pause;
  logic [DW-1:0]       mac_dout;
  logic                res_valid;
  logic [DW-1:0]       res_data;
  logic                res_ready;
  logic                busy;
  logic                done;

  int n_checks = 0;
  int n_errors = 0;

  mac_seq_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .cfg_len    (cfg_len),
    .cfg_groups (cfg_groups),
    .mem_stall  (mem_stall),
    .in_rd_en   (in_rd_en),
    .in_rd_addr (in_rd_addr),
    .w_rd_en    (w_rd_en),
    .w_rd_addr  (w_rd_addr),
    .mac_en     (mac_en),
    .mac_pause  (mac_pause),
    .mac_dout   (mac_dout),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_ready  (res_ready),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memories with one-cycle read latency and NUM_MAC multiply-accumulate lanes.
  logic [7:0]                      in_mem [IN_D];
  logic [NUM_MAC-1:0][7:0]         w_mem  [W_D];
  logic [7:0]                      rd_in_q;
  logic [NUM_MAC-1:0][7:0]         rd_w_q;
  logic [NUM_MAC-1:0][OBW-1:0]     acc;

  function automatic logic [OBW-1:0] mul(input logic [7:0] a, input logic [7:0] b);
    return OBW'(a) * OBW'(b);
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_in_q <= '0;
      rd_w_q  <= '0;
      acc     <= '0;
    end else begin
      if (in_rd_en) rd_in_q <= in_mem[in_rd_addr];
      if (w_rd_en)  rd_w_q  <= w_mem[w_rd_addr % W_D];
      for (int k = 0; k < NUM_MAC; k++) begin
        if (!mac_en)         acc[k] <= '0;
        else if (!mac_pause) acc[k] <= acc[k] + mul(rd_in_q, rd_w_q[k]);
      end
    end
  end

  assign mac_dout = acc;

  // Passive monitor: monotonic counters and logs that tests take deltas of.
  int            cyc = 0;
  int            n_reads = 0, n_res = 0, n_done = 0, n_valid = 0;
  int            n_strobe_mis = 0, n_rd_in_out = 0, n_macen_out = 0;
  int            n_unstable = 0, n_pause_armed = 0;
  int            cyc_hs = 0, cyc_done = 0;
  bit            armed = 0, prev_hold = 0;
  logic [DW-1:0] prev_data;
  int            log_in  [LOGD];
  int            log_w   [LOGD];
  int            log_cyc [LOGD];
  logic [DW-1:0] log_res [LOGD];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (in_rd_en !== w_rd_en) n_strobe_mis = n_strobe_mis + 1;
    if (armed && mac_pause) n_pause_armed = n_pause_armed + 1;
    if (in_rd_en) begin
      log_in[n_reads % LOGD]  = int'(in_rd_addr);
      log_w[n_reads % LOGD]   = int'(w_rd_addr);
      log_cyc[n_reads % LOGD] = cyc;
      n_reads = n_reads + 1;
      armed = 1;
    end else if (!busy) begin
      armed = 0;
    end
    if (res_valid && in_rd_en) n_rd_in_out = n_rd_in_out + 1;
    if (res_valid && mac_en)   n_macen_out = n_macen_out + 1;
    if (res_valid)             n_valid = n_valid + 1;
    if (prev_hold && res_valid && res_data !== prev_data) n_unstable = n_unstable + 1;
    prev_hold = res_valid && !res_ready;
    prev_data = res_data;
    if (res_valid && res_ready) begin
      log_res[n_res % LOGD] = res_data;
      n_res = n_res + 1;
      cyc_hs = cyc;
    end
    if (done) begin
      n_done = n_done + 1;
      cyc_done = cyc;
    end
  end

  // Reference: lane k of group g is the dot product of the input vector with
  // weight words g*len .. g*len+len-1.
  function automatic logic [DW-1:0] exp_word(input int g, input int len);
    logic [NUM_MAC-1:0][OBW-1:0] r;
    r = '0;
    for (int i = 0; i < len; i++)
      for (int k = 0; k < NUM_MAC; k++)
        r[k] = r[k] + mul(in_mem[i], w_mem[g * len + i][k]);
    return r;
  endfunction

  task automatic run_job(input int len, input int groups, input int stall_pct,
                         input int ready_pct, output bit timed_out);
    @(posedge clk); #1;
    start      = 1'b1;
    cfg_len    = LEN_W'(len);
    cfg_groups = GRP_W'(groups);
    mem_stall  = 1'b0;
    res_ready  = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    timed_out = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      mem_stall = ($urandom_range(99) < stall_pct);
      res_ready = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    #1;
    mem_stall = 1'b0;
    res_ready = 1'b0;
  endtask

  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0; start = 1'b0; cfg_len = '0; cfg_groups = '0;
    mem_stall = 1'b0; res_ready = 1'b0;
    #2;
    n_checks++;
    if ({in_rd_en, w_rd_en, mac_en, mac_pause, res_valid, busy, done} !== 7'b0) begin
      n_errors++;
      $display("FAIL reset_flags: got %b expected 0",
               {in_rd_en, w_rd_en, mac_en, mac_pause, res_valid, busy, done});
    end
    n_checks++;
    if (in_rd_addr !== '0 || w_rd_addr !== '0) begin
      n_errors++;
      $display("FAIL reset_addr: got in=%0d w=%0d expected 0", in_rd_addr, w_rd_addr);
    end
    n_checks++;
    if (res_data !== '0) begin
      n_errors++;
      $display("FAIL reset_res_data: got %0h expected 0", res_data);
    end
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
  endtask

  task automatic test_basic;
    int  b_rd, b_res, b_done;
    bit  to;
    logic [DW-1:0] exp;
    in_mem[0] = 8'd1; in_mem[1] = 8'd2; in_mem[2] = 8'd3;
    w_mem[0][0] = 8'd4; w_mem[1][0] = 8'd5; w_mem[2][0] = 8'd6;
    b_rd = n_reads; b_res = n_res; b_done = n_done;
    run_job(3, 1, 0, 100, to);
    n_checks++;
    if (to) begin n_errors++; $display("FAIL basic_timeout: got no done expected done"); end
    n_checks++;
    if (n_reads - b_rd != 3) begin
      n_errors++; $display("FAIL basic_reads: got %0d expected 3", n_reads - b_rd);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (log_in[(b_rd + i) % LOGD] != i || log_w[(b_rd + i) % LOGD] != i) begin
        n_errors++;
        $display("FAIL basic_addr%0d: got in=%0d w=%0d expected %0d", i,
                 log_in[(b_rd + i) % LOGD], log_w[(b_rd + i) % LOGD], i);
      end
    end
    n_checks++;
    if (log_cyc[(b_rd + 2) % LOGD] - log_cyc[b_rd % LOGD] != 2) begin
      n_errors++;
      $display("FAIL basic_consecutive: got span %0d expected 2",
               log_cyc[(b_rd + 2) % LOGD] - log_cyc[b_rd % LOGD]);
    end
    n_checks++;
    if (log_res[b_res % LOGD][OBW-1:0] !== OBW'(32)) begin
      n_errors++;
      $display("FAIL basic_lane0: got %0d expected 32", log_res[b_res % LOGD][OBW-1:0]);
    end
    exp = exp_word(0, 3);
    n_checks++;
    if (log_res[b_res % LOGD] !== exp) begin
      n_errors++; $display("FAIL basic_word: got %0h expected %0h", log_res[b_res % LOGD], exp);
    end
    n_checks++;
    if (cyc_done != cyc_hs + 1 || n_done - b_done != 1) begin
      n_errors++;
      $display("FAIL basic_done_timing: got hs=%0d done=%0d count=%0d expected done=hs+1 count=1",
               cyc_hs, cyc_done, n_done - b_done);
    end
  endtask

  task automatic test_stall;
    int  b_rd, b_res, b_pause;
    bit  to;
    logic [DW-1:0] exp;
    b_rd = n_reads; b_res = n_res; b_pause = n_pause_armed;
    @(posedge clk); #1;
    start = 1'b1; cfg_len = LEN_W'(4); cfg_groups = GRP_W'(1);
    mem_stall = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    mem_stall = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_stall = 1'b0;
    wait_done(to);
    res_ready = 1'b0;
    n_checks++;
    if (to) begin n_errors++; $display("FAIL stall_timeout: got no done expected done"); end
    n_checks++;
    if (n_pause_armed - b_pause != 2) begin
      n_errors++; $display("FAIL stall_pause_cycles: got %0d expected 2", n_pause_armed - b_pause);
    end
    n_checks++;
    if (n_reads - b_rd != 4) begin
      n_errors++; $display("FAIL stall_reads: got %0d expected 4", n_reads - b_rd);
    end
    exp = exp_word(0, 4);
    n_checks++;
    if (log_res[b_res % LOGD] !== exp) begin
      n_errors++; $display("FAIL stall_word: got %0h expected %0h", log_res[b_res % LOGD], exp);
    end
  endtask

  task automatic test_backpressure;
    int  b_rd, b_res, b_uns, b_rio, b_meo, b_val;
    bit  to, seen;
    logic [DW-1:0] exp;
    b_rd = n_reads; b_res = n_res; b_uns = n_unstable; b_rio = n_rd_in_out;
    b_meo = n_macen_out; b_val = n_valid;
    @(posedge clk); #1;
    start = 1'b1; cfg_len = LEN_W'(4); cfg_groups = GRP_W'(2);
    mem_stall = 1'b0; res_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (res_valid) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!seen) begin n_errors++; $display("FAIL bp_valid_timeout: got no res_valid expected res_valid"); end
    repeat (5) @(posedge clk);
    #1 res_ready = 1'b1;
    wait_done(to);
    res_ready = 1'b0;
    n_checks++;
    if (to) begin n_errors++; $display("FAIL bp_timeout: got no done expected done"); end
    n_checks++;
    if (n_unstable - b_uns != 0) begin
      n_errors++; $display("FAIL bp_stable: got %0d changes expected 0", n_unstable - b_uns);
    end
    n_checks++;
    if (n_rd_in_out - b_rio != 0 || n_macen_out - b_meo != 0) begin
      n_errors++;
      $display("FAIL bp_quiet_out: got reads=%0d mac_en=%0d expected 0 0",
               n_rd_in_out - b_rio, n_macen_out - b_meo);
    end
    n_checks++;
    if (n_valid - b_val < 6) begin
      n_errors++; $display("FAIL bp_valid_held: got %0d cycles expected >=6", n_valid - b_val);
    end
    n_checks++;
    if (n_reads - b_rd != 8 || log_w[(b_rd + 4) % LOGD] != 4 || log_in[(b_rd + 4) % LOGD] != 0) begin
      n_errors++;
      $display("FAIL bp_group2_addr: got reads=%0d w=%0d in=%0d expected 8 4 0",
               n_reads - b_rd, log_w[(b_rd + 4) % LOGD], log_in[(b_rd + 4) % LOGD]);
    end
    for (int g = 0; g < 2; g++) begin
      exp = exp_word(g, 4);
      n_checks++;
      if (log_res[(b_res + g) % LOGD] !== exp) begin
        n_errors++;
        $display("FAIL bp_word%0d: got %0h expected %0h", g, log_res[(b_res + g) % LOGD], exp);
      end
    end
  endtask

  task automatic test_zero_len;
    int b_rd, b_val;
    for (int t = 0; t < 2; t++) begin
      b_rd = n_reads; b_val = n_valid;
      @(posedge clk); #1;
      start = 1'b1;
      cfg_len    = (t == 0) ? LEN_W'(0) : LEN_W'(5);
      cfg_groups = (t == 0) ? GRP_W'(3) : GRP_W'(0);
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_errors++; $display("FAIL zero%0d_same_cycle: got done=%b busy=%b expected 0 0", t, done, busy);
      end
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        n_errors++; $display("FAIL zero%0d_done: got done=%b busy=%b expected 1 0", t, done, busy);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin
        n_errors++; $display("FAIL zero%0d_pulse_width: got done=%b expected 0", t, done);
      end
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (n_reads != b_rd || n_valid != b_val) begin
        n_errors++;
        $display("FAIL zero%0d_quiet: got reads=%0d valid=%0d expected 0 0", t,
                 n_reads - b_rd, n_valid - b_val);
      end
    end
  endtask

  task automatic test_reset_mid;
    int  b_done, b_rd, b_res;
    bit  hit, to;
    logic [DW-1:0] exp;
    @(posedge clk); #1;
    start = 1'b1; cfg_len = LEN_W'(8); cfg_groups = GRP_W'(1);
    mem_stall = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (in_rd_en && in_rd_addr == LEN_W'(2)) begin hit = 1'b1; break; end
    end
    n_checks++;
    if (!hit) begin n_errors++; $display("FAIL rmid_reach_idx2: got no read of 2 expected read of 2"); end
    #1;
    b_done = n_done;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({in_rd_en, w_rd_en, mac_en, mac_pause, res_valid, busy, done} !== 7'b0 ||
        in_rd_addr !== '0 || w_rd_addr !== '0 || res_data !== '0) begin
      n_errors++;
      $display("FAIL rmid_outputs: got flags=%b in=%0d w=%0d expected all 0",
               {in_rd_en, w_rd_en, mac_en, mac_pause, res_valid, busy, done}, in_rd_addr, w_rd_addr);
    end
    res_ready = 1'b0;
    @(posedge clk); #2;
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (n_done != b_done) begin
      n_errors++; $display("FAIL rmid_no_done: got %0d pulses expected 0", n_done - b_done);
    end
    b_rd = n_reads; b_res = n_res;
    run_job(3, 1, 0, 100, to);
    exp = exp_word(0, 3);
    n_checks++;
    if (to || log_in[b_rd % LOGD] != 0 || log_w[b_rd % LOGD] != 0 || log_res[b_res % LOGD] !== exp) begin
      n_errors++;
      $display("FAIL rmid_restart: got to=%0d in=%0d w=%0d res=%0h expected 0 0 0 %0h", to,
               log_in[b_rd % LOGD], log_w[b_rd % LOGD], log_res[b_res % LOGD], exp);
    end
  endtask

  task automatic test_restart_ignored;
    int  b_rd, b_res, b_done;
    bit  seen, to;
    logic [DW-1:0] exp;
    b_rd = n_reads; b_res = n_res; b_done = n_done;
    @(posedge clk); #1;
    start = 1'b1; cfg_len = LEN_W'(3); cfg_groups = GRP_W'(1);
    mem_stall = 1'b0; res_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (res_valid) begin seen = 1'b1; break; end
    end
    @(posedge clk); #1;
    start = 1'b1; cfg_len = LEN_W'(5); cfg_groups = GRP_W'(3);
    @(posedge clk); #1;
    start = 1'b0;
    res_ready = 1'b1;
    wait_done(to);
    res_ready = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    n_checks++;
    if (!seen || to) begin
      n_errors++; $display("FAIL restart_timeout: got valid=%0d timeout=%0d expected 1 0", seen, to);
    end
    n_checks++;
    if (n_reads - b_rd != 3 || n_res - b_res != 1 || n_done - b_done != 1) begin
      n_errors++;
      $display("FAIL restart_counts: got reads=%0d res=%0d done=%0d expected 3 1 1",
               n_reads - b_rd, n_res - b_res, n_done - b_done);
    end
    exp = exp_word(0, 3);
    n_checks++;
    if (log_res[b_res % LOGD] !== exp || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL restart_word: got %0h busy=%b expected %0h busy=0", log_res[b_res % LOGD], busy, exp);
    end
  endtask

  task automatic test_random;
    int  len, groups, b_rd, b_res, b_done, b_uns, b_mis;
    bit  to;
    logic [DW-1:0] exp;
    for (int j = 0; j < 8; j++) begin
      len    = int'($urandom_range(12, 1));
      groups = int'($urandom_range(4, 1));
      b_rd = n_reads; b_res = n_res; b_done = n_done; b_uns = n_unstable; b_mis = n_strobe_mis;
      run_job(len, groups, 30, 60, to);
      n_checks++;
      if (to || n_done - b_done != 1 || n_res - b_res != groups || n_reads - b_rd != len * groups) begin
        n_errors++;
        $display("FAIL rand%0d_counts: got to=%0d done=%0d res=%0d reads=%0d expected 0 1 %0d %0d",
                 j, to, n_done - b_done, n_res - b_res, n_reads - b_rd, groups, len * groups);
      end
      for (int r = 0; r < len * groups; r++) begin
        n_checks++;
        if (log_in[(b_rd + r) % LOGD] != r % len || log_w[(b_rd + r) % LOGD] != r) begin
          n_errors++;
          $display("FAIL rand%0d_addr%0d: got in=%0d w=%0d expected %0d %0d", j, r,
                   log_in[(b_rd + r) % LOGD], log_w[(b_rd + r) % LOGD], r % len, r);
        end
      end
      for (int g = 0; g < groups; g++) begin
        exp = exp_word(g, len);
        n_checks++;
        if (log_res[(b_res + g) % LOGD] !== exp) begin
          n_errors++;
          $display("FAIL rand%0d_word%0d: got %0h expected %0h", j, g, log_res[(b_res + g) % LOGD], exp);
        end
      end
      n_checks++;
      if (n_unstable != b_uns || n_strobe_mis != b_mis) begin
        n_errors++;
        $display("FAIL rand%0d_protocol: got unstable=%0d strobe_mismatch=%0d expected 0 0",
                 j, n_unstable - b_uns, n_strobe_mis - b_mis);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < IN_D; i++) in_mem[i] = 8'($urandom);
    for (int i = 0; i < W_D; i++) w_mem[i] = 32'($urandom);
    test_reset();
    test_basic();
    test_stall();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
    test_restart_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_MAC, default 4, meaning number of MAC lanes (neurons computed in parallel).
REQ-002 SHALL have parameter LEN_W, default 10, meaning width of dot-product length and input address.
REQ-003 SHALL have parameter GRP_W, default 8, meaning width of neuron-group count.
REQ-004 SHALL have parameter W_ADDR_W, default 16, meaning weight-memory address width.
REQ-005 SHALL have parameter OUT_BITWIDTH, default 26, meaning per-lane accumulator width.
REQ-006 SHALL have ports:
- clk  in  1  clock; reset rstn, asynchronous, active-low.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle job start.
- cfg_len  in  LEN_W  inputs per dot product; sampled on accepted start.
- cfg_groups  in  GRP_W  number of NUM_MAC-neuron groups; sampled on accepted start.
- mem_stall  in  1  memories cannot accept a read this cycle.
- in_rd_en  out  1  input-vector read strobe.
- in_rd_addr  out  LEN_W  input-vector read address.
- w_rd_en  out  1  weight read strobe; same cycle as in_rd_en.
- w_rd_addr  out  W_ADDR_W  weight-word address (one word = NUM_MAC weights).
- mac_en  out  1  enable to all MAC lanes.
- mac_pause  out  1  hold to all MAC lanes.
- mac_dout  in  NUM_MAC*OUT_BITWIDTH  lane accumulators, lane 0 in LSBs.
- res_valid  out  1  result word valid.
- res_data  out  NUM_MAC*OUT_BITWIDTH  captured lane accumulators.
- res_ready  in  1  downstream accepts result.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.

Function
REQ-007 SHALL implement states IDLE, RUN, LAST, CAPT, OUT.
REQ-008 IDLE: start with cfg_len!=0 and cfg_groups!=0 -> RUN; idx, grp, w_ptr cleared; busy=1 from next cycle.
REQ-009 Start with cfg_len==0 or cfg_groups==0 SHALL issue no reads, produce no results, pulse done the following cycle, stay IDLE.
REQ-010 Start outside IDLE SHALL be ignored.
REQ-011 RUN: mac_en=1; each cycle with mem_stall=0 -> in_rd_en=w_rd_en=1, in_rd_addr=idx, w_rd_addr=w_ptr, idx++ and w_ptr++; with mem_stall=1 -> no strobes, counters hold.
REQ-012 Read data SHALL be assumed valid exactly 1 cycle after strobe; mac_pause = NOT (read strobed previous cycle), in RUN and LAST.
REQ-013 Read with idx==cfg_len-1 SHALL transition RUN -> LAST; LAST (1 cycle): mac_en=1, mac_pause=0, no strobes.
REQ-014 CAPT (1 cycle): mac_en=0, mac_pause=0; res_data <= mac_dout at end of cycle; res_valid=1 from next cycle.
REQ-015 OUT: res_valid=1, res_data stable until res_valid&&res_ready; mac_en=0.
REQ-016 On OUT handshake: grp++; if grp+1==cfg_groups -> done pulse next cycle, IDLE, busy=0; else idx=0 -> RUN (w_ptr continues, not cleared).
REQ-017 mac_en SHALL be low at least one cycle between groups (CAPT) so lanes clear.
REQ-018 Counters SHALL not wrap; w_ptr width W_ADDR_W, overflow is caller's responsibility (cfg_len*cfg_groups <= 2^W_ADDR_W).
REQ-019 All outputs registered or decoded from state only; no combinational path from res_ready to res_valid.

Reset
REQ-020 rstn low SHALL force IDLE, clear idx, grp, w_ptr, res_data; all outputs 0, including mid-job; no done pulse for aborted job.

Structure
REQ-021 State encoding and default widths (LEN_W, GRP_W, OUT_BITWIDTH) SHALL live in shared package fc_pkg.
REQ-022 No sub-module; MAC lanes instantiated by parent fc_top, not here.

Verification
REQ-023 cfg_len=3, cfg_groups=1, no stall, lane0 a={1,2,3}, b={4,5,6} -> reads addr 0,1,2 on consecutive cycles, res_data lane0=32, done 1 cycle after handshake.
REQ-024 cfg_len=4, mem_stall high 2 cycles after first read -> mac_pause high exactly 2 cycles, result equals unstalled result.
REQ-025 cfg_groups=2, res_ready low 5 cycles -> res_data stable, no reads issued, second group w_rd_addr starts at cfg_len.
REQ-026 cfg_len=0 start -> zero strobes, zero res_valid, done pulse next cycle.
REQ-027 rstn asserted in RUN at idx=2 -> all outputs 0 same cycle; new start runs cleanly from addr 0.
REQ-028 start re-pulsed during OUT -> ignored, job completes with original cfg.
